mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, maximum camera words granted per burst (range 1..255).
REQ-002 Parameter STARVE_LIMIT, default 4, camera wait cycles before the camera overrides CPU priority (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cpu_req  input  1  memory-stage access request, read or write.
REQ-006 cpu_we  input  1  CPU write enable.
REQ-007 cpu_addr, cpu_wdata  input  32 each  CPU address and write data.
REQ-008 cpu_rdata  output  32  read data returned to the memory stage.
REQ-009 cpu_stall  output  1  high means the CPU is not granted; drives the pipeline pipeEnable/pcEnable low.
REQ-010 cam_req  input  1  camera write word valid.
REQ-011 cam_last  input  1  final word of the camera burst; qualified by cam_req.
REQ-012 cam_addr, cam_wdata  input  32 each  camera write address and data.
REQ-013 cam_ack  output  1  camera word accepted this cycle.
REQ-014 mem_addr, mem_wdata  output  32 each  to the single-port data memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_rdata  input  32  data memory asynchronous read data.
REQ-017 stat_cpu_stalls, stat_cam_words  output  32 each  statistics counters (see Configuration).

Function
REQ-018 Grant shall be combinational from registered state and current requests; at most one of CPU and camera is granted per cycle.
REQ-019 States: IDLE and CAM.
REQ-020 IDLE grant order: CPU first if cpu_turn=1; otherwise camera if cam_req and starve_cnt==STARVE_LIMIT; otherwise CPU if cpu_req; otherwise camera if cam_req.
REQ-021 A camera grant in IDLE shall set burst_cnt=1 and move to CAM, unless cam_last=1 or MAX_BURST==1, in which case the state stays IDLE and cpu_turn is set.
REQ-022 CAM state: the camera is granted whenever cam_req=1; burst_cnt increments per granted word.
REQ-023 CAM exits to IDLE on a granted word with cam_last=1, when burst_cnt reaches MAX_BURST, or when cam_req=0 (no grant that cycle). On exit, cpu_turn is set.
REQ-024 cpu_turn shall clear on the next CPU grant, or on any IDLE cycle with cpu_req=0.
REQ-025 starve_cnt increments, saturating at STARVE_LIMIT, each cycle cam_req=1 without a camera grant; it clears on a camera grant or when cam_req=0.
REQ-026 cpu_stall = cpu_req and not CPU-granted, in the same cycle.
REQ-027 Under a CPU grant: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we, cpu_rdata=mem_rdata.
REQ-028 Under a camera grant: mem_addr=cam_addr, mem_wdata=cam_wdata, mem_we=1, cam_ack=1.
REQ-029 With no grant: mem_we=0, cam_ack=0, mem_addr=0, mem_wdata=0.
REQ-030 cpu_rdata shall be 0 whenever the CPU is not granted.
REQ-031 Latency: a granted access completes in the same cycle; reads are combinational and writes commit on the next edge.

Reset
REQ-032 While reset=0 at an edge: state=IDLE, burst_cnt=0, starve_cnt=0, cpu_turn=0, statistics counters=0.
REQ-033 During any cycle with reset=0, mem_we=0, cam_ack=0 and cpu_stall=0.
REQ-034 A reset asserted mid-burst shall abandon the burst; no partial-burst state survives.

Configuration
REQ-035 With macro MEM_ARB_STATS_EN defined: stat_cpu_stalls counts cycles with cpu_stall=1, and stat_cam_words counts cam_ack cycles. Both are 32-bit and wrap at 2^32.
REQ-036 Without MEM_ARB_STATS_EN, both statistics ports shall be constant 0 and no counter flops shall be built.

Structure
REQ-037 Package mem_arb_pkg holds the state enum (ARB_IDLE, ARB_CAM) and the defaults MAX_BURST_DEF=8 and STARVE_LIMIT_DEF=4.
REQ-038 One sub-module, mem_arb_sat_counter (parameterised width and limit, with inc and clr inputs), implements starve_cnt.

Verification
REQ-039 CPU reads alone: cpu_req=1, cpu_we=0, cpu_addr=0x40, mem_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF, cpu_stall=0, mem_we=0.
REQ-040 Camera burst: cam_req held for 10 cycles, no cam_last, MAX_BURST=8 -> 8 consecutive cam_acks, then 1 cycle with cam_ack=0, then acks resume.
REQ-041 Contention: cpu_req=1 during camera word 3 of 8 -> cpu_stall=1 for 6 cycles; CPU granted the cycle after the burst ends; camera resumes the following cycle.
REQ-042 Starvation: cpu_req and cam_req held at 1, STARVE_LIMIT=4 -> CPU granted 4 cycles, camera granted on the 5th.
REQ-043 cam_last: a 3-word burst with cam_last on word 3 -> exactly 3 acks, then state=IDLE and cpu_turn=1.
REQ-044 Reset mid-burst: reset=0 at word 5 for 1 cycle -> mem_we=0 and cam_ack=0 that cycle; the next grant follows the IDLE order with starve_cnt=0; statistics counters read 0 when MEM_ARB_STATS_EN is defined.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/camera data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_CAM  = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_BURST_DEF    = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// Saturating up-counter used to measure how long the camera has been kept waiting.
module mem_arb_sat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  // Clear has priority; increments stop once the limit is reached.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < LIM)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between the CPU memory stage and a camera
// write stream. The camera gets bursts of up to MAX_BURST words; after every
// burst the CPU is offered one turn, and a camera kept waiting STARVE_LIMIT
// cycles overrides normal CPU priority.
// Optional statistics counters are built only when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST    = MAX_BURST_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        cam_req,
  input  logic        cam_last,
  input  logic [31:0] cam_addr,
  input  logic [31:0] cam_wdata,
  output logic        cam_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_cpu_stalls,
  output logic [31:0] stat_cam_words
);

  localparam int unsigned DATA_W     = 32;
  localparam logic [7:0]  BURST_MAX  = 8'(MAX_BURST);
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  arb_state_e  state;
  logic [7:0]  burst_cnt;
  logic [7:0]  burst_next;
  logic [7:0]  starve_cnt;
  logic        cpu_turn;
  logic        cpu_gnt;
  logic        cam_gnt;

  assign burst_next = burst_cnt + 8'd1;

  // Grant decision from registered state and the current requests; nothing
  // is granted while reset is held low.
  always_comb begin
    cpu_gnt = 1'b0;
    cam_gnt = 1'b0;
    if (reset) begin
      if (state == ARB_CAM) begin
        cam_gnt = cam_req;
      end else if (cpu_turn) begin
        cpu_gnt = cpu_req;
      end else if (cam_req && (starve_cnt == STARVE_MAX)) begin
        cam_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else begin
        cam_gnt = cam_req;
      end
    end
  end

  // Memory port steering and requester handshakes for the granted side.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_rdata = '0;
    cam_ack   = cam_gnt;
    cpu_stall = reset & cpu_req & ~cpu_gnt;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      cpu_rdata = mem_rdata;
    end else if (cam_gnt) begin
      mem_addr  = cam_addr;
      mem_wdata = cam_wdata;
      mem_we    = 1'b1;
    end
  end

  // Burst FSM: tracks burst length and hands the CPU a turn after each burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
      cpu_turn  <= 1'b0;
    end else begin
      if (cpu_gnt || ((state == ARB_IDLE) && !cpu_req)) begin
        cpu_turn <= 1'b0;
      end
      case (state)
        ARB_IDLE: begin
          if (cam_gnt) begin
            if (cam_last || (BURST_MAX == 8'd1)) begin
              cpu_turn <= 1'b1;
            end else begin
              state     <= ARB_CAM;
              burst_cnt <= 8'd1;
            end
          end
        end
        ARB_CAM: begin
          if (!cam_req || cam_last || (burst_next >= BURST_MAX)) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            cpu_turn  <= 1'b1;
          end else begin
            burst_cnt <= burst_next;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  mem_arb_sat_counter #(
    .WIDTH (8),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (cam_req & ~cam_gnt),
    .clr   (cam_gnt | ~cam_req),
    .count (starve_cnt)
  );

`ifdef MEM_ARB_STATS_EN
  logic [DATA_W-1:0] cpu_stalls_q;
  logic [DATA_W-1:0] cam_words_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_stalls_q <= '0;
      cam_words_q  <= '0;
    end else begin
      if (cpu_stall) cpu_stalls_q <= cpu_stalls_q + DATA_W'(1);
      if (cam_ack)   cam_words_q  <= cam_words_q + DATA_W'(1);
    end
  end

  assign stat_cpu_stalls = cpu_stalls_q;
  assign stat_cam_words  = cam_words_q;
`else
  assign stat_cpu_stalls = '0;
  assign stat_cam_words  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int MAXB   = 8;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        cam_req, cam_last;
  logic [31:0] cam_addr, cam_wdata;
  logic        cam_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] stat_cpu_stalls, stat_cam_words;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  bit          m_burst;
  bit          m_cpu_first;
  int          m_words;
  int          m_wait;
  int unsigned m_stalls;
  int unsigned m_camw;

  mem_arbiter #(.MAX_BURST(MAXB), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cam_req(cam_req), .cam_last(cam_last), .cam_addr(cam_addr),
    .cam_wdata(cam_wdata), .cam_ack(cam_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .stat_cpu_stalls(stat_cpu_stalls), .stat_cam_words(stat_cam_words)
  );

  always #5 clk = ~clk;

  // Who owns the memory this cycle: 0 nobody, 1 CPU, 2 camera.
  function automatic int decide();
    if (!reset) return 0;
    if (m_burst) return cam_req ? 2 : 0;
    if (m_cpu_first) return cpu_req ? 1 : 0;
    if (cam_req && m_wait >= STARVE) return 2;
    if (cpu_req) return 1;
    if (cam_req) return 2;
    return 0;
  endfunction

  task automatic advance(input int d);
    bit was_burst;
    if (!reset) begin
      m_burst = 0; m_cpu_first = 0; m_words = 0; m_wait = 0;
      m_stalls = 0; m_camw = 0;
      return;
    end
    was_burst = m_burst;
    if (cpu_req && d != 1) m_stalls++;
    if (d == 2) m_camw++;
    if (cam_req && d != 2) m_wait = (m_wait + 1 > STARVE) ? STARVE : m_wait + 1;
    else m_wait = 0;
    if (d == 1 || (!was_burst && !cpu_req)) m_cpu_first = 0;
    if (d == 2) begin
      m_words++;
      if (cam_last || m_words >= MAXB) begin
        m_burst = 0; m_words = 0; m_cpu_first = 1;
      end else begin
        m_burst = 1;
      end
    end else if (was_burst) begin
      m_burst = 0; m_words = 0; m_cpu_first = 1;
    end
  endtask

  task automatic tick();
    int d;
    d = decide();
    @(posedge clk);
    advance(d);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cam_req = 0; cam_last = 0; cam_addr = 0; cam_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick();
    cpu_req = 1; cam_req = 1; cpu_we = 1; cam_addr = 32'h100;
    @(negedge clk);
    vectors++;
    if (cam_ack !== 1'b0) begin errors++; $display("FAIL reset_cam_ack got %b want 0", cam_ack); end
    vectors++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    vectors++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got %b want 0", cpu_stall); end
    vectors++;
    if ({stat_cpu_stalls, stat_cam_words} !== 64'h0) begin
      errors++; $display("FAIL reset_stats got %h/%h want 0/0", stat_cpu_stalls, stat_cam_words);
    end
    tick();
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_rdata got %h want deadbeef", cpu_rdata); end
    vectors++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_read_stall got %b want 0", cpu_stall); end
    vectors++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL cpu_read_we got %b want 0", mem_we); end
    vectors++;
    if (mem_addr !== 32'h40) begin errors++; $display("FAIL cpu_read_addr got %h want 40", mem_addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_cam_burst();
    logic [9:0] acks;
    do_reset();
    acks = '0;
    for (int i = 0; i < 10; i++) begin
      cam_req = 1; cam_addr = 32'h1000 + i; cam_wdata = i;
      @(negedge clk);
      acks[i] = cam_ack;
      tick();
    end
    vectors++;
    if (acks !== 10'b10_1111_1111) begin
      errors++; $display("FAIL cam_burst_pattern got %b want 1011111111", acks);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_contention();
    int  stalls, gnt_at;
    bit  done, ack_after;
    do_reset();
    stalls = 0; gnt_at = -1; done = 0; ack_after = 0;
    cpu_addr = 32'h55; cpu_we = 1; cpu_wdata = 32'hCAFE;
    for (int i = 0; i < 16; i++) begin
      cam_req = 1; cam_addr = 32'h2000 + i;
      cpu_req = (i >= 2) && !done;
      @(negedge clk);
      if (cpu_req && cpu_stall) stalls++;
      if (cpu_req && !cpu_stall) begin gnt_at = i; done = 1; end
      if (gnt_at >= 0 && i == gnt_at + 1) ack_after = cam_ack;
      tick();
    end
    vectors++;
    if (stalls !== 6) begin errors++; $display("FAIL contention_stalls got %0d want 6", stalls); end
    vectors++;
    if (gnt_at !== 8) begin errors++; $display("FAIL contention_cpu_grant_cycle got %0d want 8", gnt_at); end
    vectors++;
    if (ack_after !== 1'b1) begin errors++; $display("FAIL contention_cam_resume got %b want 1", ack_after); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_starvation();
    logic [4:0] cpu_g, cam_g;
    do_reset();
    cpu_g = '0; cam_g = '0;
    for (int i = 0; i < 5; i++) begin
      cpu_req = 1; cam_req = 1; cpu_addr = 32'h80; cam_addr = 32'h3000;
      @(negedge clk);
      cpu_g[i] = ~cpu_stall;
      cam_g[i] = cam_ack;
      tick();
    end
    vectors++;
    if (cpu_g !== 5'b01111) begin errors++; $display("FAIL starve_cpu_grants got %b want 01111", cpu_g); end
    vectors++;
    if (cam_g !== 5'b10000) begin errors++; $display("FAIL starve_cam_grants got %b want 10000", cam_g); end
    do_reset();
  endtask

  task automatic test_cam_last();
    int acks;
    do_reset();
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      cam_req = 1; cam_last = (i == 2); cam_addr = 32'h4000 + i;
      @(negedge clk);
      if (cam_ack) acks++;
      tick();
    end
    vectors++;
    if (acks !== 3) begin errors++; $display("FAIL cam_last_acks got %0d want 3", acks); end
    cam_req = 1; cam_last = 0; cpu_req = 0;
    @(negedge clk);
    vectors++;
    if (cam_ack !== 1'b0) begin errors++; $display("FAIL cam_last_cpu_turn_ack got %b want 0", cam_ack); end
    tick();
    @(negedge clk);
    vectors++;
    if (cam_ack !== 1'b1) begin errors++; $display("FAIL cam_last_idle_regrant got %b want 1", cam_ack); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cam_req = 1; cam_addr = 32'h5000 + i;
      tick();
    end
    reset = 0; cpu_req = 1; cam_addr = 32'h5004;
    @(negedge clk);
    vectors++;
    if ({mem_we, cam_ack, cpu_stall} !== 3'b000) begin
      errors++; $display("FAIL midburst_reset_outputs got we/ack/stall=%b want 000", {mem_we, cam_ack, cpu_stall});
    end
    tick();
    reset = 1; cpu_req = 1; cam_req = 1; cpu_addr = 32'h99;
    @(negedge clk);
    vectors++;
    if ({cpu_stall, cam_ack, mem_addr} !== {2'b00, 32'h99}) begin
      errors++; $display("FAIL midburst_next_grant got stall=%b ack=%b addr=%h want cpu grant addr 99", cpu_stall, cam_ack, mem_addr);
    end
    vectors++;
    if ({stat_cpu_stalls, stat_cam_words} !== 64'h0) begin
      errors++; $display("FAIL midburst_stats got %h/%h want 0/0", stat_cpu_stalls, stat_cam_words);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int          d;
    logic [98:0] got, exp;
    logic [31:0] ea, ew, er;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) != 0);
      cpu_req   = ($urandom_range(0, 1) == 1);
      cpu_we    = ($urandom_range(0, 1) == 1);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cam_req   = ($urandom_range(0, 9) < 7);
      cam_last  = ($urandom_range(0, 5) == 0);
      cam_addr  = $urandom;
      cam_wdata = $urandom;
      mem_rdata = $urandom;
      @(negedge clk);
      d  = decide();
      ea = (d == 1) ? cpu_addr : (d == 2) ? cam_addr : 32'h0;
      ew = (d == 1) ? cpu_wdata : (d == 2) ? cam_wdata : 32'h0;
      er = (d == 1) ? mem_rdata : 32'h0;
      exp = {(reset && cpu_req && d != 1), (d == 2), ((d == 2) || (d == 1 && cpu_we)), ea, ew, er};
      got = {cpu_stall, cam_ack, mem_we, mem_addr, mem_wdata, cpu_rdata};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d stall/ack/we/addr/wdata/rdata got %h want %h", i, got, exp);
      end
      tick();
    end
    reset = 1;
    idle_inputs();
    @(negedge clk);
    vectors++;
`ifdef MEM_ARB_STATS_EN
    if ({stat_cpu_stalls, stat_cam_words} !== {m_stalls, m_camw}) begin
      errors++; $display("FAIL random_stats got %0d/%0d want %0d/%0d", stat_cpu_stalls, stat_cam_words, m_stalls, m_camw);
    end
`else
    if ({stat_cpu_stalls, stat_cam_words} !== 64'h0) begin
      errors++; $display("FAIL random_stats got %0d/%0d want 0/0", stat_cpu_stalls, stat_cam_words);
    end
`endif
    tick();
  endtask

  initial begin
    m_burst = 0; m_cpu_first = 0; m_words = 0; m_wait = 0; m_stalls = 0; m_camw = 0;
    idle_inputs();
    reset = 0;
    test_reset();
    test_cpu_read();
    test_cam_burst();
    test_contention();
    test_starvation();
    test_cam_last();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
